// File: rtl/stream_rr_mux.sv
// N-channel registered stream mux: round-robin or fixed-priority grant, packet lock on last.
// Optional STREAM_RR_MUX_STATS_EN adds saturating beat/packet counters (stat_beats, stat_pkts).
module stream_rr_mux #(
  parameter int unsigned  NUM_CH = 4,
  parameter int unsigned  WIDTH  = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef STREAM_RR_MUX_STATS_EN
  ,
  output logic [15:0]             stat_beats,
  output logic [15:0]             stat_pkts
`endif
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic              lock_rr_q, lock_rr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;

  logic              can_load;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt;
  logic [SEL_W-1:0]  idx;
  logic              hs;
  logic              hs_last;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_split
    assign ch_data[c] = in_data[c*WIDTH +: WIDTH];
  end

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (state_q == LOCKED) begin
      gnt     = lock_ch_q;
      gnt_vld = in_valid[lock_ch_q];
    end else if (mode) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = SEL_W'(i);
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = SEL_W'((32'(ptr_q) + i) % NUM_CH);
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  assign hs      = gnt_vld && can_load && !rst;
  assign hs_last = in_last[gnt];

  always_comb begin
    in_ready = '0;
    if (hs) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    lock_rr_d   = lock_rr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (hs) begin
      out_data_d  = ch_data[gnt];
      out_last_d  = hs_last;
      out_sel_d   = gnt;
      out_valid_d = 1'b1;
      if (state_q == IDLE && !hs_last) begin
        state_d   = LOCKED;
        lock_ch_d = gnt;
        lock_rr_d = !mode;
      end else if (state_q == LOCKED && hs_last) begin
        state_d = IDLE;
      end
      // A packet's pointer update follows the mode that granted it, not the mode at its end.
      if (hs_last && ((state_q == IDLE) ? !mode : lock_rr_q))
        ptr_d = (gnt == SEL_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_ch_q   <= '0;
      lock_rr_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      lock_rr_q   <= lock_rr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_RR_MUX_STATS_EN
  logic [15:0] beats_q, beats_d;
  logic [15:0] pkts_q, pkts_d;

  always_comb begin
    beats_d = beats_q;
    pkts_d  = pkts_q;
    if (hs && beats_q != '1) beats_d = beats_q + 16'd1;
    if (hs && hs_last && pkts_q != '1) pkts_d = pkts_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      pkts_q  <= '0;
    end else begin
      beats_q <= beats_d;
      pkts_q  <= pkts_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_pkts  = pkts_q;
`endif

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed table-driven bench for stream_rr_mux (NUM_CH=4, WIDTH=4).
module tb_stream_rr_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        mode;
  logic [3:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_RR_MUX_STATS_EN
  logic [15:0] stat_beats;
  logic [15:0] stat_pkts;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_rr_mux #(.NUM_CH(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_RR_MUX_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_pkts (stat_pkts)
`endif
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [15:0] dat;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [3:0]  od;
    logic        ol;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, registered outputs after it.
  task automatic apply(input string tag, input vec_t v);
    rst       = v.rst;
    mode      = v.mode;
    in_valid  = v.vld;
    in_last   = v.lst;
    in_data   = v.dat;
    out_ready = v.ordy;
    #3;
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(v.ov));
    chk({tag, ".out_data"},  16'(out_data),  16'(v.od));
    chk({tag, ".out_last"},  16'(out_last),  16'(v.ol));
    chk({tag, ".out_sel"},   16'(out_sel),   16'(v.os));
  endtask

  initial begin
    //          rst mode vld      lst      dat       ordy rdy      ov  od    ol  os
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 16'h1234, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 1'b1, 2'd2};
    tbl[2]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 1'b1, 2'd3};
    tbl[3]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 1'b1, 2'd2};
    tbl[6]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 1'b1, 2'd3};
    tbl[7]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 4'b1010, 4'b1010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b1, 4'b1010, 4'b1010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 1'b1, 4'b1010, 4'b1010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[12] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 1'b1, 2'd3};
    tbl[13] = '{1'b0, 1'b0, 4'b0011, 4'b0010, 16'h0065, 1'b1, 4'b0001, 1'b1, 4'h5, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 1'b0, 4'b0011, 4'b0010, 16'h0067, 1'b1, 4'b0001, 1'b1, 4'h7, 1'b0, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 4'b0011, 4'b0011, 16'h0068, 1'b1, 4'b0001, 1'b1, 4'h8, 1'b1, 2'd0};
    tbl[16] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 16'h0060, 1'b1, 4'b0010, 1'b1, 4'h6, 1'b1, 2'd1};
    tbl[17] = '{1'b0, 1'b0, 4'b0101, 4'b0000, 16'h0901, 1'b1, 4'b0100, 1'b1, 4'h9, 1'b0, 2'd2};
    tbl[18] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 16'h0A01, 1'b1, 4'b0100, 1'b1, 4'hA, 1'b1, 2'd2};
    tbl[19] = '{1'b0, 1'b1, 4'b0101, 4'b0101, 16'h0B01, 1'b1, 4'b0001, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[20] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h1, 1'b1, 2'd0};

    for (int i = 0; i < 21; i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: beat 5 held for three stalled cycles, then ch1 beat 6 loads exactly once.
    apply("bp0", '{1'b0, 1'b1, 4'b0001, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'h5, 1'b1, 2'd0});
    for (int i = 1; i <= 3; i++)
      apply($sformatf("bp%0d", i),
            '{1'b0, 1'b1, 4'b0010, 4'b0010, 16'h0060, 1'b0, 4'b0000, 1'b1, 4'h5, 1'b1, 2'd0});
    apply("bp4", '{1'b0, 1'b1, 4'b0010, 4'b0010, 16'h0060, 1'b1, 4'b0010, 1'b1, 4'h6, 1'b1, 2'd1});
    apply("bp5", '{1'b0, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h6, 1'b1, 2'd1});

    // Reset mid-packet: ch2 lock and in-flight beat dropped, ch1 then wins from ptr 0.
    apply("rs0", '{1'b0, 1'b0, 4'b0100, 4'b0000, 16'h0C00, 1'b1, 4'b0100, 1'b1, 4'hC, 1'b0, 2'd2});
    apply("rs1", '{1'b1, 1'b0, 4'b0110, 4'b0010, 16'h0C00, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0});
    apply("rs2", '{1'b0, 1'b0, 4'b0110, 4'b0110, 16'h0ED0, 1'b1, 4'b0010, 1'b1, 4'hD, 1'b1, 2'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
